// File: rtl/std_dcache_flush_unit.sv
// std_dcache_flush_unit
//
// Responder end of the data-cache flush handshake for the write-back dcache.
// When a flush is requested it waits for the cache to go quiet, then walks
// every set. For each set it reads valid/dirty/tag, issues one write-back per
// valid-and-dirty way (lowest way first), clears the set, and moves on. After
// the last set it pulses flush_ack_o for one cycle.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              flush request, held until acknowledged
//   flushing_o           flush in progress
//   flush_ack_o          one-cycle completion pulse
//   idle_i               controllers and miss handler have no outstanding work
//   arr_req_o/arr_we_o   array access request; we=0 read set, we=1 clear set
//   arr_index_o          set index of the array access
//   arr_gnt_i            array access granted this cycle
//   arr_valid_i/arr_dirty_i/arr_tag_i
//                        per-way state, valid the cycle after a granted read
//   wb_valid_o           write-back request towards the miss handler
//   wb_ready_i           write-back accepted
//   wb_tag_o/wb_index_o/wb_way_o
//                        line to write back
//
// Every output comes straight from a flop: control outputs are registered
// from the next-state decode, payloads are the set/mask/tag registers.

module std_dcache_flush_unit #(
  parameter int NUM_SETS  = 256,
  parameter int NUM_WAYS  = 8,
  parameter int TAG_WIDTH = 44,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  output logic                          flushing_o,
  output logic                          flush_ack_o,
  input  logic                          idle_i,
  output logic                          arr_req_o,
  output logic                          arr_we_o,
  output logic [IDX_W-1:0]              arr_index_o,
  input  logic                          arr_gnt_i,
  input  logic [NUM_WAYS-1:0]           arr_valid_i,
  input  logic [NUM_WAYS-1:0]           arr_dirty_i,
  input  logic [NUM_WAYS*TAG_WIDTH-1:0] arr_tag_i,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [TAG_WIDTH-1:0]          wb_tag_o,
  output logic [IDX_W-1:0]              wb_index_o,
  output logic [WAY_W-1:0]              wb_way_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_WB,
    ST_CLEAR,
    ST_ACK
  } state_t;

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  state_t                        state_reg, state_next;
  logic [IDX_W-1:0]              set_reg, set_next;
  logic [NUM_WAYS-1:0]           mask_reg, mask_next;
  logic [NUM_WAYS*TAG_WIDTH-1:0] tags_reg, tags_next;
  logic [NUM_WAYS-1:0]           mask_rest;
  logic [WAY_W-1:0]              way_next;
  logic [TAG_WIDTH-1:0]          wb_tag_next;
  logic [TAG_WIDTH-1:0]          tag_way [NUM_WAYS];

  logic                          flushing_reg;
  logic                          flush_ack_reg;
  logic                          arr_req_reg;
  logic                          arr_we_reg;
  logic                          wb_valid_reg;
  logic [TAG_WIDTH-1:0]          wb_tag_reg;
  logic [WAY_W-1:0]              wb_way_reg;

  // Mask with its lowest set bit removed: what is left after the current
  // write-back is accepted.
  assign mask_rest = mask_reg & (mask_reg - NUM_WAYS'(1));

  always_comb begin
    state_next = state_reg;
    set_next   = set_reg;
    mask_next  = mask_reg;
    tags_next  = tags_reg;
    case (state_reg)
      ST_IDLE: begin
        if (flush_i) state_next = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (idle_i) begin
          set_next   = '0;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        if (arr_gnt_i) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Only valid-and-dirty lines need writing back; everything else is
        // simply cleared.
        mask_next  = arr_valid_i & arr_dirty_i;
        tags_next  = arr_tag_i;
        state_next = (|(arr_valid_i & arr_dirty_i)) ? ST_WB : ST_CLEAR;
      end
      ST_WB: begin
        if (wb_ready_i) begin
          mask_next = mask_rest;
          if (mask_rest == '0) state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (arr_gnt_i) begin
          if (set_reg == LAST_SET) begin
            state_next = ST_ACK;
          end else begin
            set_next   = set_reg + IDX_W'(1);
            state_next = ST_READ;
          end
        end
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Lowest pending way of the next mask. Scanning downwards lets the lowest
  // index win.
  always_comb begin
    way_next = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (mask_next[w]) way_next = WAY_W'(w);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_tag_slice
      assign tag_way[gi] = tags_next[gi*TAG_WIDTH +: TAG_WIDTH];
    end
  endgenerate

  assign wb_tag_next = tag_way[way_next];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      set_reg       <= '0;
      mask_reg      <= '0;
      tags_reg      <= '0;
      flushing_reg  <= 1'b0;
      flush_ack_reg <= 1'b0;
      arr_req_reg   <= 1'b0;
      arr_we_reg    <= 1'b0;
      wb_valid_reg  <= 1'b0;
      wb_tag_reg    <= '0;
      wb_way_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      set_reg       <= set_next;
      mask_reg      <= mask_next;
      tags_reg      <= tags_next;
      flushing_reg  <= (state_next != ST_IDLE) && (state_next != ST_ACK);
      flush_ack_reg <= (state_next == ST_ACK);
      arr_req_reg   <= (state_next == ST_READ) || (state_next == ST_CLEAR);
      arr_we_reg    <= (state_next == ST_CLEAR);
      wb_valid_reg  <= (state_next == ST_WB);
      wb_tag_reg    <= wb_tag_next;
      wb_way_reg    <= way_next;
    end
  end

  assign flushing_o  = flushing_reg;
  assign flush_ack_o = flush_ack_reg;
  assign arr_req_o   = arr_req_reg;
  assign arr_we_o    = arr_we_reg;
  assign arr_index_o = set_reg;
  assign wb_valid_o  = wb_valid_reg;
  assign wb_tag_o    = wb_tag_reg;
  assign wb_index_o  = set_reg;
  assign wb_way_o    = wb_way_reg;

endmodule

// File: tb/tb_std_dcache_flush_unit.sv
// Testbench for std_dcache_flush_unit: the bench owns a model of the cache
// arrays, answers array reads/clears from it, and a scoreboard checks every
// write-back, clear and ack against the sequence the flush rules predict.

module tb_std_dcache_flush_unit;

  localparam int NS = 4;
  localparam int NW = 8;
  localparam int TW = 44;
  localparam int IW = 2;
  localparam int WW = 3;

  localparam int K_WB  = 0;
  localparam int K_CLR = 1;
  localparam int K_ACK = 2;

  typedef struct {
    int             kind;
    int             idx;
    int             way;
    logic [TW-1:0]  tag;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic             idle_i = 1'b1;
  logic             arr_gnt_i = 1'b1;
  logic             wb_ready_i = 1'b1;
  logic [NW-1:0]    arr_valid_i = '0;
  logic [NW-1:0]    arr_dirty_i = '0;
  logic [NW*TW-1:0] arr_tag_i = '0;
  logic             flushing_o, flush_ack_o, arr_req_o, arr_we_o, wb_valid_o;
  logic [IW-1:0]    arr_index_o, wb_index_o;
  logic [TW-1:0]    wb_tag_o;
  logic [WW-1:0]    wb_way_o;

  std_dcache_flush_unit #(
    .NUM_SETS (NS),
    .NUM_WAYS (NW),
    .TAG_WIDTH(TW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .flushing_o (flushing_o),
    .flush_ack_o(flush_ack_o),
    .idle_i     (idle_i),
    .arr_req_o  (arr_req_o),
    .arr_we_o   (arr_we_o),
    .arr_index_o(arr_index_o),
    .arr_gnt_i  (arr_gnt_i),
    .arr_valid_i(arr_valid_i),
    .arr_dirty_i(arr_dirty_i),
    .arr_tag_i  (arr_tag_i),
    .wb_valid_o (wb_valid_o),
    .wb_ready_i (wb_ready_i),
    .wb_tag_o   (wb_tag_o),
    .wb_index_o (wb_index_o),
    .wb_way_o   (wb_way_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cache array model and a saved copy for replaying identical contents.
  logic [NW-1:0] m_valid [NS];
  logic [NW-1:0] m_dirty [NS];
  logic [TW-1:0] m_tag   [NS][NW];
  logic [NW-1:0] s_valid [NS];
  logic [NW-1:0] s_dirty [NS];
  logic [TW-1:0] s_tag   [NS][NW];

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  int gnt_pct = 100, rdy_pct = 100, idle_pct = 100;
  int gnt_stall_cnt = 0, gnt_stall_idx = 0;
  int rdy_stall_cnt = 0, rdy_stall_way = 0;
  int idle_stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({flushing_o, flush_ack_o, arr_req_o, arr_we_o, arr_index_o,
                wb_valid_o, wb_tag_o, wb_index_o, wb_way_o});
  endfunction

  function automatic logic [TW-1:0] rand_tag();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[TW-1:0];
  endfunction

  task automatic load_clean();
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = '0;
      m_dirty[s] = '0;
      for (int w = 0; w < NW; w++) m_tag[s][w] = rand_tag();
    end
  endtask

  task automatic load_random();
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 8'($urandom());
      m_dirty[s] = 8'($urandom());
      for (int w = 0; w < NW; w++) m_tag[s][w] = rand_tag();
    end
  endtask

  // Expected flush: every set in order, its valid&dirty ways lowest first,
  // then the clear of that set; a single ack at the end.
  task automatic push_expected(output int ndirty);
    ev_t e;
    ndirty = 0;
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        if (m_valid[s][w] && m_dirty[s][w]) begin
          e.kind = K_WB; e.idx = s; e.way = w; e.tag = m_tag[s][w];
          exp_q.push_back(e);
          ndirty++;
        end
      end
      e.kind = K_CLR; e.idx = s; e.way = 0; e.tag = '0;
      exp_q.push_back(e);
    end
    e.kind = K_ACK; e.idx = 0; e.way = 0; e.tag = '0;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input int idx, input int way, input logic [TW-1:0] tag);
    ev_t e;
    $display("[cyc %0d] %s set=%0d way=%0d tag=%h", cyc,
             (kind == K_WB) ? "writeback" : (kind == K_CLR) ? "clear" : "ack",
             idx, way, tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d set %0d way %0d, required none", kind, idx, way);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      if (kind == e.kind && kind != K_ACK) chk("event_set", 64'(idx), 64'(e.idx));
      if (kind == e.kind && kind == K_WB) begin
        chk("wb_way", 64'(way), 64'(e.way));
        chk("wb_tag", 64'(tag), 64'(e.tag));
      end
    end
  endtask

  // Array responder and handshake driver.
  initial begin
    bit rd_go, clr_go;
    int rd_idx, clr_idx;
    forever begin
      @(negedge clk);
      rd_go   = rst_ni && arr_req_o && !arr_we_o && arr_gnt_i;
      clr_go  = rst_ni && arr_req_o && arr_we_o && arr_gnt_i;
      rd_idx  = int'(arr_index_o);
      clr_idx = int'(arr_index_o);
      @(posedge clk);
      #1;
      if (rd_go) begin
        arr_valid_i = m_valid[rd_idx];
        arr_dirty_i = m_dirty[rd_idx];
        for (int w = 0; w < NW; w++) arr_tag_i[w*TW +: TW] = m_tag[rd_idx][w];
      end else begin
        arr_valid_i = 8'($urandom());
        arr_dirty_i = 8'($urandom());
        for (int w = 0; w < NW; w++) arr_tag_i[w*TW +: TW] = rand_tag();
      end
      if (clr_go) begin
        m_valid[clr_idx] = '0;
        m_dirty[clr_idx] = '0;
      end
      arr_gnt_i  = (int'($urandom_range(99)) < gnt_pct);
      wb_ready_i = (int'($urandom_range(99)) < rdy_pct);
      idle_i     = (int'($urandom_range(99)) < idle_pct);
      if (gnt_stall_cnt > 0 && arr_req_o && !arr_we_o && int'(arr_index_o) == gnt_stall_idx) begin
        arr_gnt_i = 1'b0;
        gnt_stall_cnt--;
      end
      if (rdy_stall_cnt > 0 && wb_valid_o && int'(wb_way_o) == rdy_stall_way) begin
        wb_ready_i = 1'b0;
        rdy_stall_cnt--;
      end
      if (idle_stall_cnt > 0 && flushing_o && !arr_req_o && !wb_valid_o) begin
        idle_i = 1'b0;
        idle_stall_cnt--;
      end
    end
  end

  // Monitor: scoreboard pops plus hold-while-stalled checks.
  initial begin
    bit            p_req, p_gnt, p_we, p_wb, p_rdy;
    logic [IW-1:0] p_idx, p_wbidx;
    logic [WW-1:0] p_way;
    logic [TW-1:0] p_tag;
    p_req = 0; p_gnt = 0; p_we = 0; p_wb = 0; p_rdy = 0;
    p_idx = '0; p_wbidx = '0; p_way = '0; p_tag = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        p_req = 0;
        p_wb  = 0;
      end else begin
        if (p_req && !p_gnt)
          chk("arr_req_held", 64'({arr_req_o, arr_we_o, arr_index_o}), 64'({1'b1, p_we, p_idx}));
        if (p_wb && !p_rdy)
          chk("wb_payload_held", 64'({wb_valid_o, wb_way_o, wb_index_o, wb_tag_o}),
              64'({1'b1, p_way, p_wbidx, p_tag}));
        if (wb_valid_o && wb_ready_i) got(K_WB, int'(wb_index_o), int'(wb_way_o), wb_tag_o);
        if (arr_req_o && arr_we_o && arr_gnt_i) got(K_CLR, int'(arr_index_o), 0, '0);
        if (flush_ack_o) got(K_ACK, 0, 0, '0);
        p_req = arr_req_o; p_gnt = arr_gnt_i; p_we = arr_we_o; p_idx = arr_index_o;
        p_wb = wb_valid_o; p_rdy = wb_ready_i; p_way = wb_way_o;
        p_wbidx = wb_index_o; p_tag = wb_tag_o;
      end
    end
  end

  // Issues one flush and waits for its ack. extra = known stall cycles;
  // immediate = raise flush_i in the current cycle (first IDLE after an ack).
  task automatic run_flush(input int extra, input int drop_at, input bit immediate,
                           input bit timed, input string name);
    int nd, start, lat;
    bit done;
    if (!immediate) begin
      @(posedge clk);
      #1;
    end
    push_expected(nd);
    flush_i = 1'b1;
    start = cyc;
    done = 0;
    lat = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      chk({name, "_flushing"}, 64'(flushing_o), 64'((cyc - start >= 1) && !flush_ack_o));
      if (flush_ack_o) begin
        done = 1;
        lat = cyc - start;
      end
      if (drop_at >= 0 && cyc - start == drop_at) flush_i = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_timeout: got no ack, required an ack", name);
      exp_q.delete();
    end else if (timed) begin
      chk({name, "_ack_cycle"}, 64'(lat), 64'(3*NS + 2 + nd + extra));
    end
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit got_wb;
    int nd;

    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", all_outs(), 64'd0);

    // All sets invalid, everything granted immediately.
    load_clean();
    run_flush(0, -1, 0, 1, "clean");

    // Set 2: only ways 2 and 7 are valid and dirty.
    load_clean();
    m_valid[2] = 8'b1010_0110;
    m_dirty[2] = 8'b1100_0101;
    run_flush(0, -1, 0, 1, "set2");

    // Same contents, write-back of way 2 stalled for 5 cycles.
    load_clean();
    m_valid[2] = 8'b1010_0110;
    m_dirty[2] = 8'b1100_0101;
    rdy_stall_way = 2;
    rdy_stall_cnt = 5;
    run_flush(5, -1, 0, 1, "wb_stall");

    // Nothing to write back (valid-clean and invalid-dirty only), with
    // 3 grant-stall cycles on the read of set 1 and 4 not-idle cycles.
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 8'($urandom());
      m_dirty[s] = ~m_valid[s];
      for (int w = 0; w < NW; w++) m_tag[s][w] = rand_tag();
    end
    gnt_stall_idx  = 1;
    gnt_stall_cnt  = 3;
    idle_stall_cnt = 4;
    run_flush(7, -1, 0, 1, "gnt_idle_stall");

    // Reset while set 1 is waiting on a write-back.
    load_clean();
    m_valid[0] = 8'h02; m_dirty[0] = 8'h02;
    m_valid[1] = 8'h28; m_dirty[1] = 8'h28;
    push_expected(nd);
    rdy_stall_way = 3;
    rdy_stall_cnt = 1000;
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    got_wb = 0;
    for (int i = 0; i < 200 && !got_wb; i++) begin
      @(negedge clk);
      if (wb_valid_o && wb_index_o == 2'd1) got_wb = 1;
    end
    chk("reached_wb_set1", 64'(got_wb), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("reset_mid_flush_outputs", all_outs(), 64'd0);
    exp_q.delete();
    flush_i = 1'b0;
    rdy_stall_cnt = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", all_outs() & 64'h00C0_0000_0000_0000 | 64'(flushing_o), 64'd0);
    run_flush(0, -1, 0, 1, "after_reset");

    // Request dropped mid-flush, then re-raised right after the ack with the
    // same array contents.
    load_random();
    for (int s = 0; s < NS; s++) begin
      s_valid[s] = m_valid[s];
      s_dirty[s] = m_dirty[s];
      for (int w = 0; w < NW; w++) s_tag[s][w] = m_tag[s][w];
    end
    run_flush(0, 5, 0, 1, "dropped_req");
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = s_valid[s];
      m_dirty[s] = s_dirty[s];
      for (int w = 0; w < NW; w++) m_tag[s][w] = s_tag[s][w];
    end
    run_flush(0, -1, 1, 1, "rearmed");

    // Random contents with random grant/ready/idle back-pressure.
    for (int r = 0; r < 4; r++) begin
      gnt_pct  = int'($urandom_range(100, 40));
      rdy_pct  = int'($urandom_range(100, 40));
      idle_pct = int'($urandom_range(100, 40));
      load_random();
      run_flush(0, -1, 0, 0, "random");
    end
    gnt_pct = 100; rdy_pct = 100; idle_pct = 100;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
